axis_pkt_gen: RTL and testbench

//  AXI-Stream packet source placed directly upstream of the stream loopback stage.
//  It drives that stage's slave input with a deterministic pattern.

---
 rtl/axis_pkt_gen.sv | 143 ++++++++++++++
 tb/tb_axis_pkt_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: emits cfg_count packets of cfg_len beats whose tdata is a
// running beat counter, with a configurable idle gap after each packet.
module axis_pkt_gen #(
  parameter int unsigned c_WIDTH     = 8,
  parameter int unsigned c_LEN_WIDTH = 16,
  parameter int unsigned c_GAP_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [c_LEN_WIDTH-1:0] cfg_len,
  input  logic [c_LEN_WIDTH-1:0] cfg_count,
  input  logic [c_GAP_WIDTH-1:0] cfg_gap,
  output logic [c_WIDTH-1:0]     m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   done,
  output logic [c_LEN_WIDTH-1:0] pkt_sent
);

  localparam int unsigned W  = c_WIDTH;
  localparam int unsigned LW = c_LEN_WIDTH;
  localparam int unsigned GW = c_GAP_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t          state, state_next;
  logic [LW-1:0]   len_q, count_q, beat_idx;
  logic [GW-1:0]   gap_q, gap_cnt;

  logic [W-1:0]    tdata_next;
  logic            tvalid_next, tlast_next, busy_next, done_next;
  logic [LW-1:0]   pkt_sent_next, len_next, count_next, beat_next;
  logic [GW-1:0]   gap_next, gap_cnt_next;

  logic            hs_c, last_hs_c, final_c;
  logic [LW-1:0]   start_len_c;

  assign hs_c        = m_axis_tvalid & m_axis_tready;
  assign last_hs_c   = hs_c & m_axis_tlast;
  assign final_c     = (pkt_sent + LW'(1)) == count_q;
  assign start_len_c = (cfg_len == '0) ? LW'(1) : cfg_len;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt_sent      <= '0;
      beat_idx      <= '0;
      gap_cnt       <= '0;
      len_q         <= '0;
      count_q       <= '0;
      gap_q         <= '0;
    end else begin
      state         <= state_next;
      m_axis_tdata  <= tdata_next;
      m_axis_tvalid <= tvalid_next;
      m_axis_tlast  <= tlast_next;
      busy          <= busy_next;
      done          <= done_next;
      pkt_sent      <= pkt_sent_next;
      beat_idx      <= beat_next;
      gap_cnt       <= gap_cnt_next;
      len_q         <= len_next;
      count_q       <= count_next;
      gap_q         <= gap_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (cfg_count == '0) ? FIN : SEND;
      SEND: begin
        if (last_hs_c) begin
          if (final_c)            state_next = FIN;
          else if (gap_q != '0)   state_next = GAP;
        end
      end
      GAP:  if (gap_cnt == '0) state_next = SEND;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    tdata_next    = m_axis_tdata;
    tlast_next    = m_axis_tlast;
    pkt_sent_next = pkt_sent;
    beat_next     = beat_idx;
    gap_cnt_next  = gap_cnt;
    len_next      = len_q;
    count_next    = count_q;
    gap_next      = gap_q;
    case (state)
      IDLE: begin
        if (start) begin
          len_next      = start_len_c;
          count_next    = cfg_count;
          gap_next      = cfg_gap;
          tdata_next    = '0;
          pkt_sent_next = '0;
          beat_next     = '0;
          tlast_next    = (start_len_c == LW'(1));
        end
      end
      SEND: begin
        if (hs_c) begin
          tdata_next = m_axis_tdata + W'(1);
          if (m_axis_tlast) begin
            pkt_sent_next = pkt_sent + LW'(1);
            beat_next     = '0;
            tlast_next    = (len_q == LW'(1));
            gap_cnt_next  = gap_q - GW'(1);
          end else begin
            beat_next  = beat_idx + LW'(1);
            tlast_next = ((beat_idx + LW'(2)) == len_q);
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) tlast_next = (len_q == LW'(1));
        else               gap_cnt_next = gap_cnt - GW'(1);
      end
      default: ;
    endcase
    // tlast is only meaningful alongside tvalid
    if (state_next != SEND) tlast_next = 1'b0;
    tvalid_next = (state_next == SEND);
    busy_next   = (state_next == SEND) || (state_next == GAP);
    done_next   = (state_next == FIN);
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: beat order, tlast placement, gaps, backpressure,
// wrap, zero-length/zero-count handling, ignored restart and mid-packet reset.
module tb_axis_pkt_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_len;
  logic [15:0] cfg_count;
  logic [7:0]  cfg_gap;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic [15:0] pkt_sent;

  axis_pkt_gen dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_len       (cfg_len),
    .cfg_count     (cfg_count),
    .cfg_gap       (cfg_gap),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .pkt_sent      (pkt_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  int q_data[$];
  int q_last[$];
  int q_cyc[$];
  int ncyc      = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int valid_cnt = 0;
  int stab_err  = 0;
  int start_cyc = 0;
  bit stall_q   = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: records beats that handshake at the next rising edge
  always @(negedge clk) begin
    ncyc++;
    if (stall_q && !(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last))
      stab_err++;
    stall_q   = m_axis_tvalid & ~m_axis_tready;
    prev_data = m_axis_tdata;
    prev_last = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(32'(m_axis_tdata));
      q_last.push_back(32'(m_axis_tlast));
      q_cyc.push_back(ncyc);
    end
    if (m_axis_tvalid) valid_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = ncyc;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    done_cnt  = 0;
    valid_cnt = 0;
    stab_err  = 0;
  endtask

  // Caller is at posedge+1; pulses start for one cycle with the given config
  task automatic pulse_start(input int len, input int cnt, input int gap);
    cfg_len   = 16'(len);
    cfg_count = 16'(cnt);
    cfg_gap   = 8'(gap);
    start     = 1'b1;
    start_cyc = ncyc + 2;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    check("done_pulse_once", done_cnt, 1);
  endtask

  task automatic run(input int len, input int cnt, input int gap, input bit rnd);
    clear_mon();
    m_axis_tready = 1'b1;
    pulse_start(len, cnt, gap);
    wait_done(rnd);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; cfg_len = '0; cfg_count = '0; cfg_gap = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    check("rst_tvalid",   32'(m_axis_tvalid), 0);
    check("rst_tdata",    32'(m_axis_tdata),  0);
    check("rst_tlast",    32'(m_axis_tlast),  0);
    check("rst_busy",     32'(busy),          0);
    check("rst_done",     32'(done),          0);
    check("rst_pkt_sent", 32'(pkt_sent),      0);

    // 1: back-to-back packets
    run(4, 2, 0, 1'b0);
    check("t1_beats", q_data.size(), 8);
    for (int i = 0; i < q_data.size(); i++) begin
      check("t1_data", q_data[i], i);
      check("t1_last", q_last[i], (i == 3 || i == 7) ? 1 : 0);
    end
    if (q_cyc.size() == 8) begin
      check("t1_first_latency", q_cyc[0], start_cyc);
      check("t1_contiguous",    q_cyc[7] - q_cyc[0], 7);
      check("t1_done_timing",   done_cyc - q_cyc[7], 1);
    end
    check("t1_pkt_sent", 32'(pkt_sent), 2);
    check("t1_busy_end", 32'(busy), 0);

    // 2: two idle cycles between packets
    run(3, 2, 2, 1'b0);
    check("t2_beats", q_data.size(), 6);
    for (int i = 0; i < q_data.size(); i++) begin
      check("t2_data", q_data[i], i);
      check("t2_last", q_last[i], (i == 2 || i == 5) ? 1 : 0);
    end
    if (q_cyc.size() == 6) begin
      check("t2_gap",  q_cyc[3] - q_cyc[2], 3);
      check("t2_pkt0", q_cyc[2] - q_cyc[0], 2);
    end
    check("t2_pkt_sent", 32'(pkt_sent), 2);

    // 3: random backpressure
    run(5, 1, 0, 1'b1);
    check("t3_beats", q_data.size(), 5);
    for (int i = 0; i < q_data.size(); i++) begin
      check("t3_data", q_data[i], i);
      check("t3_last", q_last[i], (i == 4) ? 1 : 0);
    end
    check("t3_stable", stab_err, 0);
    check("t3_pkt_sent", 32'(pkt_sent), 1);

    // 4: tdata wrap in a long packet
    run(300, 1, 0, 1'b0);
    check("t4_beats", q_data.size(), 300);
    for (int i = 0; i < q_data.size(); i++) begin
      check("t4_data", q_data[i], i % 256);
      check("t4_last", q_last[i], (i == 299) ? 1 : 0);
    end

    // 5a: zero packets
    run(4, 0, 0, 1'b0);
    check("t5a_valid_cnt", valid_cnt, 0);
    check("t5a_pkt_sent", 32'(pkt_sent), 0);

    // 5b: zero length behaves as one beat
    run(0, 3, 0, 1'b0);
    check("t5b_beats", q_data.size(), 3);
    for (int i = 0; i < q_data.size(); i++) begin
      check("t5b_data", q_data[i], i);
      check("t5b_last", q_last[i], 1);
    end
    check("t5b_pkt_sent", 32'(pkt_sent), 3);

    // 6a: a second start mid-run is ignored
    clear_mon();
    m_axis_tready = 1'b1;
    pulse_start(4, 2, 0);
    check("t6a_busy", 32'(busy), 1);
    repeat (2) @(posedge clk);
    #1;
    cfg_len = 16'd1; cfg_count = 16'd5; cfg_gap = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0);
    check("t6a_beats", q_data.size(), 8);
    for (int i = 0; i < q_data.size(); i++) begin
      check("t6a_data", q_data[i], i);
      check("t6a_last", q_last[i], (i == 3 || i == 7) ? 1 : 0);
    end
    check("t6a_pkt_sent", 32'(pkt_sent), 2);

    // 6b: reset while beat 2 of 4 is presented
    clear_mon();
    m_axis_tready = 1'b1;
    pulse_start(4, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t6b_pre_tdata", 32'(m_axis_tdata), 2);
    check("t6b_pre_busy",  32'(busy), 1);
    #1 rst = 1'b0;
    #1;
    check("t6b_rst_tvalid", 32'(m_axis_tvalid), 0);
    check("t6b_rst_tdata",  32'(m_axis_tdata),  0);
    check("t6b_rst_tlast",  32'(m_axis_tlast),  0);
    check("t6b_rst_busy",   32'(busy),          0);
    check("t6b_rst_pkt",    32'(pkt_sent),      0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    run(2, 1, 0, 1'b0);
    check("t6b_beats", q_data.size(), 2);
    for (int i = 0; i < q_data.size(); i++) begin
      check("t6b_data", q_data[i], i);
      check("t6b_last", q_last[i], (i == 1) ? 1 : 0);
    end
    check("t6b_pkt_sent", 32'(pkt_sent), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
